// File: rtl/spi_pkg.sv
// Shared constants for the 24-bit opcode/data SPI frame protocol.
package spi_pkg;

    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_INIT    = 8'h01;
    localparam logic [7:0] OP_WR_INV  = 8'h02;
    localparam logic [7:0] OP_RD_INV  = 8'h03;
    localparam logic [7:0] OP_WR_LEDS = 8'h04;
    localparam logic [7:0] OP_RD_LEDS = 8'h05;

    localparam int FRAME_BITS = 24;
    localparam int STAT_WR_OK = 6;
    localparam int STAT_RD_OK = 7;
    localparam int DATA_LSB   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

endpackage

// File: rtl/spi_master_if.sv
// Command/response handshake bundle between on-chip logic and spi_master.
interface spi_master_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [15:0] cmd_data;
    logic        resp_valid;
    logic        resp_ack;
    logic [23:0] resp_data;
    logic        busy;

    modport master (
        output cmd_valid, cmd_opcode, cmd_data, resp_ack,
        input  cmd_ready, resp_valid, resp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_data, resp_ack,
        output cmd_ready, resp_valid, resp_data, busy
    );

endinterface

// File: rtl/spi_sck_div.sv
// SCK half-period timer: one-cycle tick every CLK_DIV clocks while running.
module spi_sck_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_restart,
    input  logic i_run,
    output logic o_tick
);

    localparam int W = $clog2(CLK_DIV);

    logic [W-1:0] r_cnt;

    assign o_tick = i_run && (r_cnt == W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || i_restart) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI master: sends {data, opcode} LSB first, returns the 24-bit MISO frame.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int SS_GAP  = 8
) (
    input  logic clk,
    input  logic reset,
    output logic SPI_SCK,
    output logic SPI_SS,
    output logic SPI_MOSI,
    input  logic SPI_MISO,
    spi_master_if.slave bus
);

    localparam int GW = $clog2(SS_GAP);
    localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

    state_t r_state;
    state_t w_next;

    logic        r_ss;
    logic        r_sck;
    logic        r_mosi;
    logic        r_resp_valid;
    logic        r_busy;
    logic [23:0] r_resp_data;
    logic [23:0] r_tx;
    logic [23:0] r_rx;
    logic [4:0]  r_bit_cnt;
    logic [GW-1:0] r_gap_cnt;

    logic w_accept;
    logic w_run;
    logic w_tick;
    logic w_gap_done;

    assign bus.cmd_ready  = (r_state == ST_IDLE) && !r_resp_valid && !reset;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.busy       = r_busy;
    assign SPI_SS   = r_ss;
    assign SPI_SCK  = r_sck;
    assign SPI_MOSI = r_mosi;

    assign w_accept   = bus.cmd_valid && bus.cmd_ready;
    assign w_gap_done = (r_gap_cnt == GW'(SS_GAP - 1));
    assign w_run      = (r_state == ST_SETUP) || (r_state == ST_HIGH) ||
                        (r_state == ST_LOW)   || (r_state == ST_HOLD);

    spi_sck_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk       (clk),
        .reset     (reset),
        .i_restart (w_accept),
        .i_run     (w_run),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_accept) w_next = ST_SETUP;
            ST_SETUP: if (w_tick) w_next = ST_HIGH;
            ST_HIGH:  if (w_tick) w_next = (r_bit_cnt == LAST_BIT) ? ST_HOLD : ST_LOW;
            ST_LOW:   if (w_tick) w_next = ST_HIGH;
            ST_HOLD:  if (w_tick) w_next = ST_GAP;
            ST_GAP:   if (w_gap_done) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ss         <= 1'b1;
            r_sck        <= 1'b0;
            r_mosi       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_busy       <= 1'b0;
            r_tx         <= '0;
            r_rx         <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
        end else begin
            if (r_resp_valid && bus.resp_ack) r_resp_valid <= 1'b0;
            unique case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_tx      <= {bus.cmd_data, bus.cmd_opcode};
                    r_ss      <= 1'b0;
                    r_mosi    <= bus.cmd_opcode[0];
                    r_busy    <= 1'b1;
                    r_bit_cnt <= '0;
                    r_rx      <= '0;
                end
                ST_SETUP, ST_LOW: if (w_tick) begin
                    // MISO was updated a full half-period ago by the slave
                    r_sck            <= 1'b1;
                    r_rx[r_bit_cnt]  <= SPI_MISO;
                end
                ST_HIGH: if (w_tick) begin
                    r_sck <= 1'b0;
                    if (r_bit_cnt != LAST_BIT) begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        r_mosi    <= r_tx[r_bit_cnt + 5'd1];
                    end
                end
                ST_HOLD: if (w_tick) begin
                    r_ss         <= 1'b1;
                    r_mosi       <= 1'b0;
                    r_resp_data  <= r_rx;
                    r_resp_valid <= 1'b1;
                    r_gap_cnt    <= '0;
                end
                ST_GAP: begin
                    r_gap_cnt <= r_gap_cnt + GW'(1);
                    if (w_gap_done) r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
